exec_preproc_pipe: RTL and testbench
====================================

Name: exec_preproc_pipe

Overview:
- Parametrised, flow-controlled successor of the execute-stage operand preprocessor.
- Decodes the 7-bit control word (operation[6:4], immediate flag [3], opselect[2:0]) and selects ALU/shifter operands.
- Adds valid/ready handshakes on both sides and a wait state for memory-read data.
- Sits between the decode/issue stage and the arithmetic/shift units.

Parameters:
- DATA_W, 32, operand/result width (≥8, power of two).
- SHAMT_W, $clog2(DATA_W), shift-amount width (derived; not overridden).
- IMM_SH_LSB, 6, LSB of the shift-amount field inside imm.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept this cycle.
- control_in  in  7  {operation[6:4], imm_flag[3], opselect[2:0]}.
- src1, src2, imm  in  DATA_W  signed register operands / sign-extended immediate.
- mem_rd_valid  in  1  mem_data_read_in valid (sampled only in WAIT_MEM).
- mem_data_read_in  in  DATA_W  memory read data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- aluin1, aluin2  out  DATA_W  ALU operands.
- operation_out, opselect_out  out  3  registered control fields.
- shift_number  out  SHAMT_W  shift amount.
- enable_arith, enable_shift, mem_data_wr_en  out  1  beat qualifiers, 0 unless out_valid.
- mem_data_write_out  out  DATA_W  store data (registered src2).

Behaviour:
- Reset (synchronous, active-high): state=IDLE; out_valid=0; all data/control outputs=0; in_ready=0 during reset cycle. Mid-WAIT_MEM reset drops the pending load silently.
- States: IDLE, WAIT_MEM.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Accept in IDLE: aluin1<=src1; operation_out<=ctl[6:4]; opselect_out<=ctl[2:0]; mem_data_write_out<=src2. Then by opselect:
  - ARITH_LOGIC (001): aluin2<=ctl[3] ? imm : src2; enable_arith=1; out_valid<=1.
  - SHIFT_REG (000): shift_number<=ctl[3] ? src2[SHAMT_W-1:0] : imm[IMM_SH_LSB+SHAMT_W-1:IMM_SH_LSB]; enable_shift=1; aluin2 held; out_valid<=1.
  - MEM_WRITE (100): mem_data_wr_en=ctl[3]; enables 0; aluin2 held; out_valid<=1.
  - MEM_READ (101), ctl[3]=1: out_valid<=0; go to WAIT_MEM.
  - MEM_READ (101), ctl[3]=0: enables 0; aluin2 held; out_valid<=1.
  - Any other opselect: bubble beat; all enables 0; out_valid<=1.
- WAIT_MEM: on mem_rd_valid: aluin2<=mem_data_read_in; enable_arith=1; out_valid<=1; return to IDLE. Otherwise hold, with no timeout.
- mem_rd_valid in IDLE is ignored. Earliest sampling is the cycle after accept.
- Latency: 1 cycle accept→out_valid; memory read is 1 cycle after mem_rd_valid. Throughput 1 beat/cycle when out_ready is held high.
- Backpressure: while out_valid && !out_ready, all outputs are stable and in_ready=0.
- Simultaneous out handshake and accept: the old beat retires and the new beat loads the same edge, with no bubble.
- shift_number is 0 on every non-shift beat.
- Enables and mem_data_wr_en are 1 only while out_valid=1 and are cleared on retire with no replacement.

Optional Feature:
- Macro EXEC_PREPROC_ILLEGAL_EN.
- Defined: adds output illegal_op (1 bit), asserted with any bubble beat for an undefined opselect. Also adds a sticky illegal_seen bit, cleared only by reset.
- Undefined: ports absent; undefined opselects still produce the bubble beat.

Decomposition:
- Package exec_pkg: opselect codes, ALU and shift operation codes, load-type codes, and typedef ctl_t (packed struct {operation, imm_flag, opselect}).
- Sub-module exec_preproc_decode: combinational ctl_t → operand-select, enables and shift-source.
- The FSM and registers stay in the top module.

Test Plan:
- ARITH imm: ctl=7'b000_1_001, src1=5, imm=-3, out_ready=1 → next cycle out_valid=1, aluin1=5, aluin2=-3, enable_arith=1, enable_shift=0.
- SHIFT reg: ctl=7'b010_1_000, src2=32'h0000_0025 → shift_number=5'd5, enable_shift=1. SHIFT imm: ctl[3]=0, imm=32'h0000_0380 → shift_number=14.
- Load wait: ctl=7'b000_1_101, mem_rd_valid raised 3 cycles later with data 32'hDEAD_BEEF → in_ready=0 throughout; out_valid rises 1 cycle after, aluin2=DEADBEEF, enable_arith=1.
- Backpressure: 4 back-to-back ARITH beats, out_ready low for cycles 2–4 → outputs frozen; no beat lost or duplicated; order preserved.
- Store: ctl=7'b000_1_100, src2=77 → mem_data_wr_en=1 and mem_data_write_out=77 for exactly one beat; enables 0.
- Reset mid-load: assert reset in WAIT_MEM → next cycle state IDLE, out_valid=0, and a later mem_rd_valid produces no beat.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared control-word layout and operation codes for the execute-stage operand preprocessor.
package exec_pkg;

    localparam logic [2:0] OPSEL_SHIFT_REG   = 3'b000;
    localparam logic [2:0] OPSEL_ARITH_LOGIC = 3'b001;
    localparam logic [2:0] OPSEL_MEM_WRITE   = 3'b100;
    localparam logic [2:0] OPSEL_MEM_READ    = 3'b101;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_HADD = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_NOT  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_LHG  = 3'b111;

    localparam logic [2:0] SHIFT_LEFT_LOG  = 3'b000;
    localparam logic [2:0] SHIFT_RIGHT_LOG = 3'b001;
    localparam logic [2:0] SHIFT_LEFT_AR   = 3'b010;
    localparam logic [2:0] SHIFT_RIGHT_AR  = 3'b011;

    localparam logic [2:0] LOAD_BYTE   = 3'b000;
    localparam logic [2:0] LOAD_HALF   = 3'b001;
    localparam logic [2:0] LOAD_WORD   = 3'b011;
    localparam logic [2:0] LOAD_BYTE_U = 3'b100;
    localparam logic [2:0] LOAD_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        ALU2_KEEP = 2'd0,
        ALU2_SRC2 = 2'd1,
        ALU2_IMM  = 2'd2
    } alu2_sel_e;

    typedef struct packed {
        logic [2:0] operation;
        logic       imm_flag;
        logic [2:0] opselect;
    } ctl_t;

endpackage

// File: rtl/exec_preproc_decode.sv
// Combinational control-word decode: operand-2 source, beat qualifiers and shift-amount source.
// EXEC_PREPROC_ILLEGAL_EN adds the undefined-opselect flag.
module exec_preproc_decode
    import exec_pkg::*;
(
    input  ctl_t       i_ctl,
    output logic [2:0] o_operation,
    output logic [2:0] o_opselect,
    output alu2_sel_e  o_alu2_sel,
    output logic       o_en_arith,
    output logic       o_en_shift,
    output logic       o_mem_wr_en,
    output logic       o_shamt_from_src2,
`ifdef EXEC_PREPROC_ILLEGAL_EN
    output logic       o_illegal,
`endif
    output logic       o_wait_mem
);

    assign o_operation = i_ctl.operation;
    assign o_opselect  = i_ctl.opselect;

    always_comb begin
        o_alu2_sel        = ALU2_KEEP;
        o_en_arith        = 1'b0;
        o_en_shift        = 1'b0;
        o_mem_wr_en       = 1'b0;
        o_shamt_from_src2 = 1'b0;
        o_wait_mem        = 1'b0;
`ifdef EXEC_PREPROC_ILLEGAL_EN
        o_illegal         = 1'b0;
`endif
        case (i_ctl.opselect)
            OPSEL_ARITH_LOGIC: begin
                o_alu2_sel = i_ctl.imm_flag ? ALU2_IMM : ALU2_SRC2;
                o_en_arith = 1'b1;
            end
            // Register form takes the amount from src2; immediate form from a field inside imm.
            OPSEL_SHIFT_REG: begin
                o_en_shift        = 1'b1;
                o_shamt_from_src2 = i_ctl.imm_flag;
            end
            OPSEL_MEM_WRITE: o_mem_wr_en = i_ctl.imm_flag;
            OPSEL_MEM_READ:  o_wait_mem  = i_ctl.imm_flag;
            default: begin
`ifdef EXEC_PREPROC_ILLEGAL_EN
                o_illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/exec_preproc_pipe.sv
// Flow-controlled execute-stage operand preprocessor with a wait state for memory-read data.
// EXEC_PREPROC_ILLEGAL_EN adds illegal_op / sticky illegal_seen outputs.
module exec_preproc_pipe
    import exec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IMM_SH_LSB = 6,
    localparam int SHAMT_W   = $clog2(DATA_W)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          control_in,
    input  logic [DATA_W-1:0]   src1,
    input  logic [DATA_W-1:0]   src2,
    input  logic [DATA_W-1:0]   imm,
    input  logic                mem_rd_valid,
    input  logic [DATA_W-1:0]   mem_data_read_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   aluin1,
    output logic [DATA_W-1:0]   aluin2,
    output logic [2:0]          operation_out,
    output logic [2:0]          opselect_out,
    output logic [SHAMT_W-1:0]  shift_number,
    output logic                enable_arith,
    output logic                enable_shift,
    output logic                mem_data_wr_en,
`ifdef EXEC_PREPROC_ILLEGAL_EN
    output logic                illegal_op,
    output logic                illegal_seen,
`endif
    output logic [DATA_W-1:0]   mem_data_write_out
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_MEM = 1'b1;

    logic [0:0]         r_state;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_aluin1;
    logic [DATA_W-1:0]  r_aluin2;
    logic [2:0]         r_operation;
    logic [2:0]         r_opselect;
    logic [SHAMT_W-1:0] r_shift_number;
    logic               r_en_arith;
    logic               r_en_shift;
    logic               r_mem_wr_en;
    logic [DATA_W-1:0]  r_mem_wr_data;

    logic [2:0]         w_operation;
    logic [2:0]         w_opselect;
    alu2_sel_e          w_alu2_sel;
    logic               w_en_arith;
    logic               w_en_shift;
    logic               w_mem_wr_en;
    logic               w_shamt_from_src2;
    logic               w_wait_mem;
    logic               w_accept;
    logic               w_retire;
    logic [SHAMT_W-1:0] w_shamt;

    exec_preproc_decode u_decode (
        .i_ctl             (ctl_t'(control_in)),
        .o_operation       (w_operation),
        .o_opselect        (w_opselect),
        .o_alu2_sel        (w_alu2_sel),
        .o_en_arith        (w_en_arith),
        .o_en_shift        (w_en_shift),
        .o_mem_wr_en       (w_mem_wr_en),
        .o_shamt_from_src2 (w_shamt_from_src2),
`ifdef EXEC_PREPROC_ILLEGAL_EN
        .o_illegal         (w_illegal),
`endif
        .o_wait_mem        (w_wait_mem)
    );

`ifdef EXEC_PREPROC_ILLEGAL_EN
    logic w_illegal;
    logic r_illegal_op;
    logic r_illegal_seen;
`endif

    assign in_ready = !reset && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_retire = r_out_valid && out_ready;
    assign w_shamt  = w_shamt_from_src2 ? src2[SHAMT_W-1:0]
                                        : imm[IMM_SH_LSB+SHAMT_W-1:IMM_SH_LSB];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_out_valid    <= 1'b0;
            r_aluin1       <= '0;
            r_aluin2       <= '0;
            r_operation    <= '0;
            r_opselect     <= '0;
            r_shift_number <= '0;
            r_en_arith     <= 1'b0;
            r_en_shift     <= 1'b0;
            r_mem_wr_en    <= 1'b0;
            r_mem_wr_data  <= '0;
        end else begin
            // Retire clears the qualifiers; a same-edge accept below overrides them.
            if (w_retire) begin
                r_out_valid <= 1'b0;
                r_en_arith  <= 1'b0;
                r_en_shift  <= 1'b0;
                r_mem_wr_en <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_aluin1       <= src1;
                        r_operation    <= w_operation;
                        r_opselect     <= w_opselect;
                        r_mem_wr_data  <= src2;
                        r_shift_number <= w_en_shift ? w_shamt : '0;
                        if (w_alu2_sel == ALU2_SRC2) begin
                            r_aluin2 <= src2;
                        end else if (w_alu2_sel == ALU2_IMM) begin
                            r_aluin2 <= imm;
                        end
                        r_en_arith  <= w_en_arith;
                        r_en_shift  <= w_en_shift;
                        r_mem_wr_en <= w_mem_wr_en;
                        r_out_valid <= !w_wait_mem;
                        if (w_wait_mem) begin
                            r_state <= ST_WAIT_MEM;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_rd_valid) begin
                        r_aluin2    <= mem_data_read_in;
                        r_en_arith  <= 1'b1;
                        r_en_shift  <= 1'b0;
                        r_mem_wr_en <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef EXEC_PREPROC_ILLEGAL_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_illegal_op   <= 1'b0;
            r_illegal_seen <= 1'b0;
        end else begin
            if (w_retire) begin
                r_illegal_op <= 1'b0;
            end
            if (w_accept) begin
                r_illegal_op <= w_illegal;
                if (w_illegal) begin
                    r_illegal_seen <= 1'b1;
                end
            end
        end
    end

    assign illegal_op   = r_illegal_op;
    assign illegal_seen = r_illegal_seen;
`endif

    assign out_valid          = r_out_valid;
    assign aluin1             = r_aluin1;
    assign aluin2             = r_aluin2;
    assign operation_out      = r_operation;
    assign opselect_out       = r_opselect;
    assign shift_number       = r_shift_number;
    assign enable_arith       = r_en_arith;
    assign enable_shift       = r_en_shift;
    assign mem_data_wr_en     = r_mem_wr_en;
    assign mem_data_write_out = r_mem_wr_data;

endmodule

// File: tb/tb_exec_preproc_pipe.sv
// Scoreboard bench for exec_preproc_pipe: directed cases followed by randomized traffic with backpressure.
module tb_exec_preproc_pipe;

    localparam int DW = 32;
    localparam int SW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    control_in;
    logic [DW-1:0] src1, src2, imm;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_data_read_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] aluin1, aluin2;
    logic [2:0]    operation_out, opselect_out;
    logic [SW-1:0] shift_number;
    logic          enable_arith, enable_shift, mem_data_wr_en;
    logic [DW-1:0] mem_data_write_out;
`ifdef EXEC_PREPROC_ILLEGAL_EN
    logic          illegal_op, illegal_seen;
`endif

    exec_preproc_pipe #(.DATA_W(DW), .IMM_SH_LSB(6)) dut (
        .clock              (clock),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .control_in         (control_in),
        .src1               (src1),
        .src2               (src2),
        .imm                (imm),
        .mem_rd_valid       (mem_rd_valid),
        .mem_data_read_in   (mem_data_read_in),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .aluin1             (aluin1),
        .aluin2             (aluin2),
        .operation_out      (operation_out),
        .opselect_out       (opselect_out),
        .shift_number       (shift_number),
        .enable_arith       (enable_arith),
        .enable_shift       (enable_shift),
        .mem_data_wr_en     (mem_data_wr_en),
`ifdef EXEC_PREPROC_ILLEGAL_EN
        .illegal_op         (illegal_op),
        .illegal_seen       (illegal_seen),
`endif
        .mem_data_write_out (mem_data_write_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] a1;
        logic [DW-1:0] a2;
        logic [DW-1:0] wd;
        logic [2:0]    op;
        logic [2:0]    os;
        logic [SW-1:0] sh;
        logic          ea;
        logic          es;
        logic          wr;
        logic          ill;
    } beat_t;

    beat_t         exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] m_alu2;
    bit            m_ill_seen;
    bit            in_wait;
    beat_t         pend_load;
    bit            bp_en;
    int            rdy_lo;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference behaviour derived from the opselect rules, with plain arithmetic on the fields.
    function automatic beat_t model(input logic [6:0] ctl, input logic [DW-1:0] s1,
                                    input logic [DW-1:0] s2, input logic [DW-1:0] im);
        beat_t       b;
        int unsigned osel;
        bit          immf;
        osel = int'(ctl) % 8;
        immf = ((int'(ctl) / 8) % 2) == 1;
        b    = '0;
        b.a1 = s1;
        b.a2 = m_alu2;
        b.wd = s2;
        b.op = 3'(int'(ctl) / 16);
        b.os = 3'(osel);
        case (osel)
            1: begin b.a2 = immf ? im : s2; b.ea = 1'b1; end
            0: begin b.sh = immf ? SW'(s2 % 32) : SW'((im / 64) % 32); b.es = 1'b1; end
            4: b.wr = immf;
            5: ;
            default: begin
`ifdef EXEC_PREPROC_ILLEGAL_EN
                b.ill = 1'b1;
`endif
            end
        endcase
        return b;
    endfunction

    function automatic beat_t dut_beat();
        beat_t b;
        b.a1 = aluin1;
        b.a2 = aluin2;
        b.wd = mem_data_write_out;
        b.op = operation_out;
        b.os = opselect_out;
        b.sh = shift_number;
        b.ea = enable_arith;
        b.es = enable_shift;
        b.wr = mem_data_wr_en;
`ifdef EXEC_PREPROC_ILLEGAL_EN
        b.ill = illegal_op;
`else
        b.ill = 1'b0;
`endif
        return b;
    endfunction

    task automatic tick();
        @(negedge clock);
        in_valid = 1'b0;
        if (rdy_lo > 0) begin
            out_ready = 1'b0;
            rdy_lo--;
        end else begin
            out_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        mem_rd_valid     = in_wait ? 1'b0 : ($urandom_range(0, 3) == 0);
        mem_data_read_in = $urandom;
        control_in       = 7'($urandom);
        src1             = $urandom;
        src2             = $urandom;
        imm              = $urandom;
    endtask

    task automatic issue(input logic [6:0] ctl, input logic [DW-1:0] s1,
                         input logic [DW-1:0] s2, input logic [DW-1:0] im);
        int    guard = 0;
        bit    done  = 0;
        beat_t b;
        while (!done) begin
            tick();
            in_valid   = 1'b1;
            control_in = ctl;
            src1       = s1;
            src2       = s2;
            imm        = im;
            #1;
            if (in_ready) begin
                done = 1;
                b    = model(ctl, s1, s2, im);
                if (b.os == 3'b101 && ctl[3]) begin
                    pend_load = b;
                    in_wait   = 1'b1;
                end else begin
                    m_alu2 = b.a2;
                    if (b.ill) m_ill_seen = 1'b1;
                    exp_q.push_back(b);
                end
            end else if (++guard > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL issue_timeout: in_ready stuck at 0 for ctl %b", ctl);
                done = 1;
            end
        end
    endtask

    task automatic deliver(input int dly, input logic [DW-1:0] d);
        beat_t b;
        repeat (dly) begin
            tick();
            in_valid = 1'b1;
            #1;
            chk("wait_in_ready", DW'(in_ready), '0);
        end
        tick();
        in_valid         = 1'b1;
        mem_rd_valid     = 1'b1;
        mem_data_read_in = d;
        #1;
        chk("deliver_in_ready", DW'(in_ready), '0);
        b      = pend_load;
        b.a2   = d;
        b.ea   = 1'b1;
        m_alu2 = d;
        exp_q.push_back(b);
        in_wait = 1'b0;
    endtask

    // Monitor: pops on every output handshake, and checks that held beats stay frozen.
    initial begin
        beat_t cur, snap, e;
        bit    have_snap = 0;
        forever begin
            @(negedge clock);
            #2;
            if (reset !== 1'b0) begin
                have_snap = 0;
            end else begin
                cur = dut_beat();
                if (have_snap) begin
                    n_cmp++;
                    if (cur !== snap || out_valid !== 1'b1) begin
                        n_bad++;
                        $display("FAIL hold: got %h valid %b want %h valid 1", cur, out_valid, snap);
                    end
                end
                have_snap = 0;
                if (out_valid === 1'b1) begin
                    if (out_ready !== 1'b1) begin
                        snap      = cur;
                        have_snap = 1;
                    end else begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_bad++;
                            $display("FAIL unexpected_beat: got %h want no beat", cur);
                        end else begin
                            e = exp_q.pop_front();
                            if (cur !== e) begin
                                n_bad++;
                                $display("FAIL beat: got %h want %h", cur, e);
                            end
                        end
                    end
                end else begin
                    n_cmp++;
                    if ({enable_arith, enable_shift, mem_data_wr_en} !== 3'b000) begin
                        n_bad++;
                        $display("FAIL idle_quals: got %b want 000",
                                 {enable_arith, enable_shift, mem_data_wr_en});
                    end
                end
            end
        end
    end

    initial begin
        logic [6:0] ctl;
        int         g;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mem_rd_valid = 1'b0;
        control_in = '0; src1 = '0; src2 = '0; imm = '0; mem_data_read_in = '0;
        m_alu2 = '0; m_ill_seen = 0; in_wait = 0; bp_en = 0; rdy_lo = 0;

        repeat (3) @(negedge clock);
        #1;
        chk("rst_in_ready", DW'(in_ready), '0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_aluin1", aluin1, '0);
        chk("rst_aluin2", aluin2, '0);
        chk("rst_ctl", DW'({operation_out, opselect_out, shift_number}), '0);
        chk("rst_wdata", mem_data_write_out, '0);
        chk("idle_in_ready", DW'(in_ready), 1);

        issue(7'b000_1_001, 32'd5, 32'd9, 32'hFFFF_FFFD);
        issue(7'b010_1_000, 32'd1, 32'h0000_0025, 32'h0000_1234);
        issue(7'b010_0_000, 32'd2, 32'h0000_FFFF, 32'h0000_0380);
        issue(7'b000_1_101, 32'd11, 32'd22, 32'd33);
        deliver(3, 32'hDEAD_BEEF);
        issue(7'b000_1_100, 32'd3, 32'd77, 32'd0);
        issue(7'b011_0_010, 32'd4, 32'd5, 32'd6);
        issue(7'b000_0_101, 32'd7, 32'd8, 32'd9);
        issue(7'b001_0_001, 32'd100, 32'd200, 32'd300);
        rdy_lo = 3;
        issue(7'b010_0_001, 32'd101, 32'd201, 32'd301);
        issue(7'b100_1_001, 32'd102, 32'd202, 32'd302);
        issue(7'b101_0_001, 32'd103, 32'd203, 32'd303);

        // Reset while a load is waiting for memory data.
        issue(7'b000_1_101, 32'd55, 32'd66, 32'd77);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rstmid_in_ready", DW'(in_ready), '0);
        tick();
        reset = 1'b0;
        in_wait = 0; m_alu2 = '0; m_ill_seen = 0;
        exp_q.delete();
        #1;
        chk("rstmid_out_valid", DW'(out_valid), '0);
        chk("rstmid_in_ready_idle", DW'(in_ready), 1);
        repeat (3) begin
            tick();
            mem_rd_valid = 1'b1;
            #1;
            chk("no_ghost_load", DW'(out_valid), '0);
        end

        bp_en = 1;
        for (int i = 0; i < 300; i++) begin
            ctl = 7'($urandom);
            issue(ctl, $urandom, $urandom, $urandom);
            if (in_wait) deliver($urandom_range(0, 4), $urandom);
            if ($urandom_range(0, 7) == 0) tick();
        end

        bp_en = 0;
        g = 0;
        while (exp_q.size() > 0 && g < 100) begin
            tick();
            g++;
        end
        tick();
        chk("drain", DW'(exp_q.size()), '0);
`ifdef EXEC_PREPROC_ILLEGAL_EN
        chk("illegal_seen", DW'(illegal_seen), DW'(m_ill_seen));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
